// File: rtl/mem_lsu.sv
// Load/store unit: initiator side of the data-memory port (IDLE/WAIT/RESP handshake with timeout).
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module mem_lsu #(
    parameter int unsigned MEM_BYTES   = 21,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_funct3_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        bus_err_o,
    output logic        misalign_o,
    output logic        mem_req_o,
    output logic        mem_memRW_o,
    output logic [1:0]  mem_dataSec_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_dataW_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_f3;
    logic        r_req;
    logic        r_rw;
    logic [1:0]  r_sec;
    logic [31:0] r_addr;
    logic [31:0] r_dataw;
    logic [31:0] r_rdata;
    logic        r_rvalid;
    logic        r_berr;
    logic        r_mis;

    logic        w_legal;
    logic [2:0]  w_size;
    logic [1:0]  w_sec;
    logic [32:0] w_end;
    logic        w_fault;
    logic        w_misalign;
    logic [31:0] w_fmt;

    always_comb begin
        w_legal = 1'b0;
        w_size  = '0;
        w_sec   = '0;
        case (lsu_funct3_i)
            3'b000: begin w_legal = 1'b1;      w_size = 3'd1; w_sec = 2'b00; end
            3'b100: begin w_legal = !lsu_we_i; w_size = 3'd1; w_sec = 2'b00; end
            3'b001: begin w_legal = 1'b1;      w_size = 3'd2; w_sec = 2'b01; end
            3'b101: begin w_legal = !lsu_we_i; w_size = 3'd2; w_sec = 2'b01; end
            3'b010: begin w_legal = 1'b1;      w_size = 3'd4; w_sec = 2'b10; end
            default: ;
        endcase
    end

    // Last byte computed in 33 bits so accesses near 0xFFFFFFFF cannot wrap into range.
    assign w_end   = {1'b0, lsu_addr_i} + {30'd0, w_size} - 33'd1;
    assign w_fault = !w_legal || (w_end >= 33'(MEM_BYTES));

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((w_sec == 2'b01) && lsu_addr_i[0]) ||
                        ((w_sec == 2'b10) && (lsu_addr_i[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Byte at addr arrives in [31:24], so narrow loads take the top of the word.
    always_comb begin
        case (r_f3)
            3'b000:  w_fmt = {{24{mem_data_i[31]}}, mem_data_i[31:24]};
            3'b100:  w_fmt = {24'd0, mem_data_i[31:24]};
            3'b001:  w_fmt = {{16{mem_data_i[31]}}, mem_data_i[31:16]};
            3'b101:  w_fmt = {16'd0, mem_data_i[31:16]};
            default: w_fmt = mem_data_i;
        endcase
    end

    assign stall_o = (r_state == S_IDLE) ? lsu_valid_i : (r_state == S_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_f3     <= '0;
            r_req    <= 1'b0;
            r_rw     <= 1'b1;
            r_sec    <= '0;
            r_addr   <= '0;
            r_dataw  <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_berr   <= 1'b0;
            r_mis    <= 1'b0;
        end else begin
            r_berr   <= 1'b0;
            r_mis    <= 1'b0;
            r_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (lsu_valid_i) begin
                        if (w_fault) begin
                            r_berr <= 1'b1;
                        end else if (w_misalign) begin
                            r_mis <= 1'b1;
                        end else begin
                            r_req   <= 1'b1;
                            r_rw    <= !lsu_we_i;
                            r_sec   <= w_sec;
                            r_addr  <= lsu_addr_i;
                            r_dataw <= lsu_we_i ? lsu_wdata_i : '0;
                            r_we    <= lsu_we_i;
                            r_f3    <= lsu_funct3_i;
                            r_cnt   <= '0;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Ack is tested first so it wins over a coincident timeout.
                    if (mem_ack_i) begin
                        r_req    <= 1'b0;
                        r_rvalid <= !r_we;
                        if (!r_we) begin
                            r_rdata <= w_fmt;
                        end
                        r_state  <= S_RESP;
                    end else if (r_cnt == 8'(TIMEOUT_CYC - 1)) begin
                        r_req   <= 1'b0;
                        r_berr  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rdata_o       = r_rdata;
    assign rdata_valid_o = r_rvalid;
    assign bus_err_o     = r_berr;
    assign misalign_o    = r_mis;
    assign mem_req_o     = r_req;
    assign mem_memRW_o   = r_rw;
    assign mem_dataSec_o = r_sec;
    assign mem_addr_o    = r_addr;
    assign mem_dataW_o   = r_dataw;

endmodule
